// File: rtl/instr_mem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package instr_mem_arb_pkg;

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_P0   = 2'd1,
      RESP_P1   = 2'd2
   } resp_owner_t;

   // Counter width able to hold 0..limit; never narrower than one bit.
   function automatic int unsigned starve_w(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/instr_arb_starve_ctr.sv
// Saturating denial counter; at_limit_o flags that the starved port must win next.
module instr_arb_starve_ctr
   import instr_mem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int unsigned   CW      = starve_w(LIMIT);
   localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIMIT_C)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/instr_mem_arbiter.sv
// Two-port arbiter in front of the single-port instruction memory (RAM + boot ROM).
// Port 1 (bus) has priority; port 0 (fetch) is forced through after STARVE_LIMIT denials.
module instr_mem_arbiter
   import instr_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    p0_req_i,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   output logic                    p0_gnt_o,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,
   input  logic                    p1_req_i,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic                    p1_we_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_gnt_o,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,
   output logic                    mem_en_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic        starve_at_limit;
   logic        p0_gnt;
   logic        p1_gnt;
   resp_owner_t resp_q;
   resp_owner_t resp_d;

   // Grant: bus wins contention unless fetch has been denied STARVE_LIMIT times in a row.
   always_comb begin
      p1_gnt = p1_req_i & ~(p0_req_i & starve_at_limit);
      p0_gnt = p0_req_i & ~p1_gnt;
   end

   instr_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (p0_req_i & ~p0_gnt),
      .clr_i      (p0_gnt | ~p0_req_i),
      .at_limit_o (starve_at_limit)
   );

   // Memory mux; address MSB (ROM select) passes through untouched.
   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (p1_gnt) begin
         mem_addr_o  = p1_addr_i;
         mem_we_o    = p1_we_i;
         mem_be_o    = p1_be_i;
         mem_wdata_o = p1_wdata_i;
      end else if (p0_gnt) begin
         mem_addr_o  = p0_addr_i;
         mem_be_o    = {BE_WIDTH{1'b1}};
      end
   end

   always_comb begin
      resp_d = RESP_NONE;
      if (p1_gnt) begin
         resp_d = RESP_P1;
      end else if (p0_gnt) begin
         resp_d = RESP_P0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q <= RESP_NONE;
      end else begin
         resp_q <= resp_d;
      end
   end

   assign mem_en_o    = p0_gnt | p1_gnt;
   assign p0_gnt_o    = p0_gnt;
   assign p1_gnt_o    = p1_gnt;
   assign p0_rvalid_o = (resp_q == RESP_P0);
   assign p1_rvalid_o = (resp_q == RESP_P1);
   assign p0_rdata_o  = mem_rdata_i;
   assign p1_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: a behavioural RAM/ROM drives mem_rdata_i, and a
// reference memory plus response queue supply every expected value.
module tb_instr_mem_arbiter;
   import instr_mem_arb_pkg::*;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   typedef struct {
      resp_owner_t   port;
      logic          chk_data;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          p0_req_i, p1_req_i, p1_we_i;
   logic [AW-1:0] p0_addr_i, p1_addr_i;
   logic [BW-1:0] p1_be_i;
   logic [DW-1:0] p1_wdata_i;
   logic          p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
   logic [DW-1:0] p0_rdata_o, p1_rdata_o;
   logic          mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [BW-1:0] mem_be_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;

   logic [DW-1:0] mem     [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   exp_t          sb_q    [$];
   logic [DW-1:0] last_rd;
   int            n_pass = 0;
   int            n_total = 0;

   always #5 clk = ~clk;

   instr_mem_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .p0_req_i    (p0_req_i),
      .p0_addr_i   (p0_addr_i),
      .p0_gnt_o    (p0_gnt_o),
      .p0_rvalid_o (p0_rvalid_o),
      .p0_rdata_o  (p0_rdata_o),
      .p1_req_i    (p1_req_i),
      .p1_addr_i   (p1_addr_i),
      .p1_we_i     (p1_we_i),
      .p1_be_i     (p1_be_i),
      .p1_wdata_i  (p1_wdata_i),
      .p1_gnt_o    (p1_gnt_o),
      .p1_rvalid_o (p1_rvalid_o),
      .p1_rdata_o  (p1_rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_addr_o  (mem_addr_o),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
      return 32'hB007_0000 | DW'(a);
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [BW-1:0] be,
                                           input logic [DW-1:0] wd);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < int'(BW); b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (a[AW-1]) return rom_val(a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   // Memory wrapper model, driven only by the DUT's memory port.
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_addr_o[AW-1]) begin
            mem_rdata_i <= rom_val(mem_addr_o);
         end else if (mem_we_o) begin
            mem[mem_addr_o] = merge(mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0, mem_be_o, mem_wdata_o);
         end else begin
            mem_rdata_i <= mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock: drive at negedge, check grant/memory drive, then check the response a cycle later.
   task automatic step(input logic r0, input logic [AW-1:0] a0, input logic r1, input logic [AW-1:0] a1,
                       input logic we, input logic [BW-1:0] be, input logic [DW-1:0] wd,
                       input logic eg0, input logic eg1, input string tag);
      exp_t          e;
      logic [AW-1:0] ea;
      logic          ewe;
      logic [BW-1:0] ebe;
      logic [DW-1:0] ewd;
      @(negedge clk);
      p0_req_i = r0; p0_addr_i = a0;
      p1_req_i = r1; p1_addr_i = a1; p1_we_i = we; p1_be_i = be; p1_wdata_i = wd;
      #1;
      ea = '0; ewe = 1'b0; ebe = '0; ewd = '0;
      if (eg1) begin
         ea = a1; ewe = we; ebe = be; ewd = wd;
      end else if (eg0) begin
         ea = a0; ebe = '1;
      end
      check({tag, ".p0_gnt"},    64'(p0_gnt_o),    64'(eg0));
      check({tag, ".p1_gnt"},    64'(p1_gnt_o),    64'(eg1));
      check({tag, ".mem_en"},    64'(mem_en_o),    64'(eg0 | eg1));
      check({tag, ".mem_addr"},  64'(mem_addr_o),  64'(ea));
      check({tag, ".mem_we"},    64'(mem_we_o),    64'(ewe));
      check({tag, ".mem_be"},    64'(mem_be_o),    64'(ebe));
      check({tag, ".mem_wdata"}, 64'(mem_wdata_o), 64'(ewd));
      e.port = RESP_NONE; e.chk_data = 1'b0; e.data = '0;
      if (eg0) begin
         e.port = RESP_P0; e.chk_data = 1'b1; e.data = ref_read(a0);
      end else if (eg1) begin
         e.port = RESP_P1;
         if (we) begin
            if (!a1[AW-1]) ref_mem[a1] = merge(ref_read(a1), be, wd);
         end else begin
            e.chk_data = 1'b1; e.data = ref_read(a1);
         end
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check({tag, ".p0_rvalid"}, 64'(p0_rvalid_o), 64'(e.port == RESP_P0));
      check({tag, ".p1_rvalid"}, 64'(p1_rvalid_o), 64'(e.port == RESP_P1));
      if (e.chk_data) begin
         last_rd = (e.port == RESP_P0) ? p0_rdata_o : p1_rdata_o;
         check({tag, ".rdata"}, 64'(last_rd), 64'(e.data));
      end
   endtask

   task automatic idle(input string tag);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      rst_n = 1'b0;
      p0_req_i = 1'b0; p0_addr_i = '0;
      p1_req_i = 1'b0; p1_addr_i = '0; p1_we_i = 1'b0; p1_be_i = '0; p1_wdata_i = '0;
      for (int a = 0; a < 64; a += 4) begin
         mem[AW'(a)]     = 32'h1000_0000 | DW'(a);
         ref_mem[AW'(a)] = 32'h1000_0000 | DW'(a);
      end
      repeat (2) @(posedge clk);
      #1;
      check("reset.p0_rvalid", 64'(p0_rvalid_o), 64'(0));
      check("reset.p1_rvalid", 64'(p1_rvalid_o), 64'(0));
      check("reset.mem_en",    64'(mem_en_o),    64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Fetch-only, back to back, straight out of reset.
      step(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "s1a");
      step(1'b1, 16'h0014, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "s1b");
      idle("s1_idle");

      // Bus write then fetch of the same word.
      step(1'b0, 16'h0, 1'b1, 16'h0020, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, "s2w");
      step(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "s2r");
      check("s2.deadbeef", 64'(last_rd), 64'(32'hDEAD_BEEF));

      // Both requesting: 4 bus grants then one fetch, repeating.
      for (int i = 0; i < 11; i++)
         step(1'b1, 16'h0040, 1'b1, 16'h0044, 1'b0, 4'h0, 32'h0, (i % 5) == 4, (i % 5) != 4, "s3");
      idle("s3_idle");

      // Partial-byte write over an all-ones word.
      step(1'b0, 16'h0, 1'b1, 16'h0030, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, "s4w0");
      step(1'b0, 16'h0, 1'b1, 16'h0030, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 1'b1, "s4w1");
      step(1'b0, 16'h0, 1'b1, 16'h0030, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, "s4r");
      check("s4.merged", 64'(last_rd), 64'(32'hFFFF_5678));

      // ROM fetch then RAM bus read back to back; data must not cross over.
      step(1'b0, 16'h0, 1'b1, 16'h0004, 1'b1, 4'hF, 32'hA5A5_0004, 1'b0, 1'b1, "s5w");
      step(1'b1, 16'h8000, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "s5rom");
      check("s5.rom_data", 64'(last_rd), 64'(32'hB007_8000));
      step(1'b0, 16'h0, 1'b1, 16'h0004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, "s5ram");
      check("s5.ram_data", 64'(last_rd), 64'(32'hA5A5_0004));

      // Build up denials, then reset right after a bus read grant.
      step(1'b1, 16'h0010, 1'b1, 16'h0008, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, "s6pre");
      @(negedge clk);
      #1;
      check("s6.p1_gnt", 64'(p1_gnt_o), 64'(1));
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("s6.p1_rvalid_dropped", 64'(p1_rvalid_o), 64'(0));
      check("s6.p0_rvalid_dropped", 64'(p0_rvalid_o), 64'(0));
      @(negedge clk);
      p0_req_i = 1'b0; p1_req_i = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++)
         step(1'b1, 16'h0010, 1'b1, 16'h0008, 1'b0, 4'h0, 32'h0, i == 4, i != 4, "s6starve");
      step(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, "s6p0");
      idle("s6_idle");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
